// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the pipeline, the arbiter and the memory.
// The arbiter takes the slave side; the pipeline and memory drive the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_cancel;
  logic              fetch_done;
  logic [DATA_W-1:0] fetch_rdata;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_done;
  logic [DATA_W-1:0] data_rdata;

  logic              stall_if;
  logic              stall_mem;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output fetch_req, fetch_addr, fetch_cancel,
    output data_req, data_we, data_addr, data_wdata,
    output mem_rdata,
    input  fetch_done, fetch_rdata,
    input  data_done, data_rdata,
    input  stall_if, stall_mem,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  fetch_req, fetch_addr, fetch_cancel,
    input  data_req, data_we, data_addr, data_wdata,
    input  mem_rdata,
    output fetch_done, fetch_rdata,
    output data_done, data_rdata,
    output stall_if, stall_mem,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and MEM stage.
// Data has priority; a streak counter lets a waiting fetch through eventually.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              own_fetch_q, own_fetch_d;
  logic              cancel_q, cancel_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fetch_done_q, fetch_done_d;
  logic              data_done_q, data_done_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic fetch_m;
  logic data_m;
  logic guard;
  logic grant_data;
  logic grant_fetch;
  logic kill;

  // A requester in its done cycle is masked so it is not granted twice.
  assign fetch_m     = bus.fetch_req & ~fetch_done_q;
  assign data_m      = bus.data_req & ~data_done_q;
  assign guard       = (streak_q == STREAK_MAX);
  assign grant_data  = data_m & ~(fetch_m & guard);
  assign grant_fetch = fetch_m & ~grant_data;
  assign kill        = cancel_q | (own_fetch_q & bus.fetch_cancel);

  // Next-state, arbitration and access sequencing.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    cnt_d         = cnt_q;
    own_fetch_d   = own_fetch_q;
    cancel_d      = cancel_q;
    mem_en_d      = 1'b0;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_done_d  = 1'b0;
    data_done_d   = 1'b0;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (grant_data) begin
          state_d     = S_ISSUE;
          own_fetch_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = bus.data_we;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wdata;
          if (bus.fetch_req && !guard) begin
            streak_d = streak_q + SW'(1);
          end
        end else if (grant_fetch) begin
          state_d     = S_ISSUE;
          own_fetch_d = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.fetch_addr;
          streak_d    = '0;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
        if (own_fetch_q && bus.fetch_cancel) begin
          cancel_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = S_IDLE;
          cancel_d = 1'b0;
          if (own_fetch_q) begin
            if (!kill) begin
              fetch_done_d  = 1'b1;
              fetch_rdata_d = bus.mem_rdata;
            end
          end else begin
            data_done_d = 1'b1;
            if (!mem_we_q) begin
              data_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (own_fetch_q && bus.fetch_cancel) begin
            cancel_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      streak_q      <= '0;
      cnt_q         <= '0;
      own_fetch_q   <= 1'b0;
      cancel_q      <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      cnt_q         <= cnt_d;
      own_fetch_q   <= own_fetch_d;
      cancel_q      <= cancel_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_done_q  <= fetch_done_d;
      data_done_q   <= data_done_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.fetch_rdata = fetch_rdata_q;
  assign bus.data_done   = data_done_q;
  assign bus.data_rdata  = data_rdata_q;
  assign bus.stall_if    = bus.fetch_req & ~fetch_done_q;
  assign bus.stall_mem   = bus.data_req & ~data_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model, request drivers, scoreboard.
// Expected read data is queued at request time and matched on done pulses.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LATENCY(LAT),
    .MAX_STREAK(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[7:0], a[15:8]} ^ 16'h3C3C;
  endfunction

  int          rcnt = 0;
  logic [15:0] rval = '0;

  always @(posedge clk) begin
    if (rcnt > 0) rcnt <= rcnt - 1;
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        rcnt <= LAT;
        rval <= rd(bus.mem_addr);
      end
    end
  end

  assign bus.mem_rdata = (rcnt == 1) ? rval : 16'hDEAD;

  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [15:0] w;
    int          c;
  } gnt_t;

  exp_t fq[$];
  exp_t dq[$];
  gnt_t glog[$];
  int   fdone_n = 0;
  logic fd_prev = 1'b0;
  logic dd_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    check("stall_if", bus.stall_if, bus.fetch_req & ~bus.fetch_done);
    check("stall_mem", bus.stall_mem, bus.data_req & ~bus.data_done);
    if (bus.mem_en)
      glog.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata, cyc});
    if (bus.fetch_done || bus.data_done)
      check("done_excl", bus.fetch_done & bus.data_done, 0);
    if (bus.fetch_done) begin
      fdone_n++;
      check("f_width", fd_prev, 0);
      if (fq.size() == 0) begin
        check("f_unexp", fq.size(), 1);
      end else begin
        e = fq.pop_front();
        check("f_rdata", bus.fetch_rdata, e.d);
        if (e.c >= 0) check("f_cyc", cyc, e.c);
      end
    end
    if (bus.data_done) begin
      check("d_width", dd_prev, 0);
      if (dq.size() == 0) begin
        check("d_unexp", dq.size(), 1);
      end else begin
        e = dq.pop_front();
        check("d_rdata", bus.data_rdata, e.d);
        if (e.c >= 0) check("d_cyc", cyc, e.c);
      end
    end
    fd_prev = bus.fetch_done;
    dd_prev = bus.data_done;
  end

  logic [15:0] last_f = '0;
  logic [15:0] last_d = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_f, input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = is_f ? bus.fetch_done : bus.data_done;
    end
    check(tag, seen, 1);
  endtask

  task automatic fetch_op(input logic [15:0] a, input int ec);
    bus.fetch_addr = a;
    bus.fetch_req  = 1'b1;
    fq.push_back('{rd(a), ec});
    last_f = rd(a);
    wait_done(1'b1, "f_timeout");
    step();
    bus.fetch_req = 1'b0;
  endtask

  task automatic data_op(input logic we, input logic [15:0] a,
                         input logic [15:0] w, input int ec);
    logic [15:0] ex;
    ex = we ? last_d : rd(a);
    last_d = ex;
    bus.data_we    = we;
    bus.data_addr  = a;
    bus.data_wdata = w;
    bus.data_req   = 1'b1;
    dq.push_back('{ex, ec});
    wait_done(1'b0, "d_timeout");
    step();
    bus.data_req = 1'b0;
  endtask

  task automatic check_zero(input string p);
    check({p, "_mem_en"}, bus.mem_en, 0);
    check({p, "_mem_we"}, bus.mem_we, 0);
    check({p, "_mem_addr"}, bus.mem_addr, 0);
    check({p, "_mem_wdata"}, bus.mem_wdata, 0);
    check({p, "_fdone"}, bus.fetch_done, 0);
    check({p, "_ddone"}, bus.data_done, 0);
    check({p, "_frdata"}, bus.fetch_rdata, 0);
    check({p, "_drdata"}, bus.data_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int n0;
    int fi;
    int fcnt;
    logic [15:0] old_d;

    reset            = 1'b1;
    bus.fetch_req    = 1'b0;
    bus.fetch_addr   = '0;
    bus.fetch_cancel = 1'b0;
    bus.data_req     = 1'b0;
    bus.data_we      = 1'b0;
    bus.data_addr    = '0;
    bus.data_wdata   = '0;
    mem[16'h0010]    = 16'hA5C3;

    repeat (2) step();
    @(negedge clk);
    check_zero("rst");
    step();
    reset = 1'b0;
    step();

    // single fetch
    step();
    r = cyc;
    glog.delete();
    fetch_op(16'h0010, r + 4);
    check("sf_n", glog.size(), 1);
    check("sf_cyc", glog[0].c, r + 1);
    check("sf_we", glog[0].we, 0);
    check("sf_addr", glog[0].a, 16'h0010);
    check("sf_rdata", bus.fetch_rdata, 16'hA5C3);

    // collision
    step();
    r = cyc;
    glog.delete();
    fork
      fetch_op(16'h0020, r + 8);
      data_op(1'b0, 16'h8000, 16'h0000, r + 4);
    join
    check("col_n", glog.size(), 2);
    check("col_a0", glog[0].a, 16'h8000);
    check("col_c0", glog[0].c, r + 1);
    check("col_a1", glog[1].a, 16'h0020);
    check("col_c1", glog[1].c, r + 5);

    // store
    step();
    r = cyc;
    old_d = last_d;
    glog.delete();
    fork
      data_op(1'b1, 16'h8002, 16'h1234, r + 4);
      begin
        repeat (3) @(negedge clk);
        check("st_hold_en", bus.mem_en, 0);
        check("st_hold_we", bus.mem_we, 1);
        check("st_hold_a", bus.mem_addr, 16'h8002);
        check("st_hold_w", bus.mem_wdata, 16'h1234);
      end
    join
    check("st_n", glog.size(), 1);
    check("st_c", glog[0].c, r + 1);
    check("st_we", glog[0].we, 1);
    check("st_a", glog[0].a, 16'h8002);
    check("st_w", glog[0].w, 16'h1234);
    check("st_drdata", bus.data_rdata, old_d);
    check("st_mem", rd(16'h8002), 16'h1234);
    step();
    r = cyc;
    data_op(1'b0, 16'h8002, 16'h0000, r + 4);
    check("st_load", bus.data_rdata, 16'h1234);

    // data held continuously while a fetch waits
    step();
    glog.delete();
    fork
      fetch_op(16'h0040, -1);
      for (int k = 0; k < 6; k++)
        data_op(1'b0, 16'h8100 + 16'(k), 16'h0000, -1);
    join
    fi = -1;
    fcnt = 0;
    foreach (glog[i]) begin
      if (glog[i].a == 16'h0040) begin
        fcnt++;
        if (fi < 0) fi = i;
      end
    end
    check("sv_total", glog.size(), 7);
    check("sv_fgrants", fcnt, 1);
    check("sv_bound", (fi >= 0) && (fi <= MAXS), 1);

    // fetch cancel with pending data
    step();
    r = cyc;
    n0 = fdone_n;
    glog.delete();
    bus.fetch_addr = 16'h0030;
    bus.fetch_req  = 1'b1;
    step();
    bus.fetch_cancel = 1'b1;
    bus.data_we      = 1'b0;
    bus.data_addr    = 16'h8004;
    bus.data_wdata   = 16'h0000;
    bus.data_req     = 1'b1;
    dq.push_back('{rd(16'h8004), r + 8});
    last_d = rd(16'h8004);
    step();
    bus.fetch_cancel = 1'b0;
    bus.fetch_req    = 1'b0;
    wait_done(1'b0, "c_timeout");
    step();
    bus.data_req = 1'b0;
    check("c_nodone", fdone_n, n0);
    check("c_frdata", bus.fetch_rdata, last_f);
    check("c_n", glog.size(), 2);
    check("c_a0", glog[0].a, 16'h0030);
    check("c_c0", glog[0].c, r + 1);
    check("c_a1", glog[1].a, 16'h8004);
    check("c_c1", glog[1].c, r + 5);

    // reset in the middle of a fetch wait
    step();
    n0 = fdone_n;
    bus.fetch_addr = 16'h0050;
    bus.fetch_req  = 1'b1;
    step();
    step();
    reset         = 1'b1;
    bus.fetch_req = 1'b0;
    step();
    @(negedge clk);
    check_zero("rmid");
    step();
    reset = 1'b0;
    repeat (6) step();
    check("rmid_nodone", fdone_n, n0);
    step();
    r = cyc;
    glog.delete();
    fetch_op(16'h0060, r + 4);
    check("rmid_n", glog.size(), 1);
    check("rmid_c", glog[0].c, r + 1);
    check("rmid_a", glog[0].a, 16'h0060);

    repeat (3) step();
    check("fq_left", fq.size(), 0);
    check("dq_left", dq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
